vga_cursor_gen: RTL and testbench
=================================

Name: vga_cursor_gen

Overview:
- Parametrised cursor generator for the VGA text controller. It replaces the single-cycle address-equality flag with a pipelined compare, a scanline-range cursor shape, and a frame-counted blink engine.
- Sits between the character address counter / glyph row counter and the pixel mux.
- Drives o_cursor_h, which the pixel path uses to invert or force foreground on the current glyph pixels.

Parameters:
- ADDR_W, 11, width of character cell address (cursor position and output character address).
- ROW_W, 4, width of glyph scanline index within a character cell.
- BLINK_FRAMES, 16, frames per blink half-period in slow-blink mode; must be an even value of 2 or more.
- CNT_W, 5, blink frame counter width; must satisfy 2^CNT_W > BLINK_FRAMES.

Ports:
- i_clk  in  1  pixel/character clock.
- i_rst_h  in  1  synchronous reset, active-high.
- i_cur_pos_addr  in  ADDR_W  current cursor cell address.
- i_out_addr_char  in  ADDR_W  cell address currently being output.
- i_char_row  in  ROW_W  scanline index within the current cell, aligned with i_out_addr_char.
- i_start_row  in  ROW_W  first cursor scanline, inclusive.
- i_end_row  in  ROW_W  last cursor scanline, inclusive.
- i_mode  in  2  0=off, 1=steady, 2=slow blink, 3=fast blink.
- i_frame_start_h  in  1  one-cycle pulse, once per frame.
- o_cursor_h  out  1  cursor pixel enable for the cell/row presented 2 cycles earlier.
- o_blink_phase_h  out  1  current blink phase (1 = visible half).

Behaviour:
- Reset (i_rst_h=1 at a clock edge) has the following effects:
  - o_cursor_h=0, o_blink_phase_h=1.
  - Blink counter=0.
  - Pipeline stage registers=0.
  - Previous-position register=0.
- Reset asserted mid-frame has these effects:
  - All state is cleared on that edge.
  - o_cursor_h is 0 for the reset cycle plus the 2 pipeline-fill cycles that follow.
- Stage 1 (registered) computes:
  - hit1 = (i_cur_pos_addr == i_out_addr_char).
  - row1 = (i_start_row <= i_char_row) AND (i_char_row <= i_end_row), unsigned compare.
  - If i_start_row > i_end_row, row1=0: the cursor is hidden, VGA-compatible, with no wrap-around.
  - i_start_row == i_end_row gives a single-scanline cursor.
- Stage 2 (registered): o_cursor_h = hit1 AND row1 AND en, where en is:
  - mode 0: 0.
  - mode 1: 1.
  - modes 2/3: blink phase.
- Mode is sampled at stage 2. Total latency from inputs to o_cursor_h is 2 cycles.
- Blink engine counts i_frame_start_h pulses. Half-period H = BLINK_FRAMES in mode 2, and BLINK_FRAMES/2 in mode 3.
  - On a pulse with counter == H-1: counter<=0 and phase toggles.
  - On any other pulse: counter+1.
  - If the mode changes to a smaller H and the counter is already >= H-1, the next pulse toggles and clears the counter. No lockup is allowed.
  - In modes 0/1, the counter holds 0 and phase holds 1.
- Move restart: a previous-position register samples i_cur_pos_addr every cycle.
  - If the current value differs from the previous one (move detected), counter<=0 and phase<=1 on that edge, so the cursor is immediately visible after a move.
  - Move detect overrides a simultaneous i_frame_start_h.
- o_blink_phase_h is registered and equals the phase register.
- Address wrap needs no special handling: all comparisons are pure equality or unsigned compares over the full widths.

Decomposition:
- Package vga_cursor_pkg holds:
  - mode constants CUR_OFF=0, CUR_STEADY=1, CUR_BLINK_SLOW=2, CUR_BLINK_FAST=3;
  - the 2-bit mode typedef.
- Sub-module vga_cursor_blink contains the frame counter, phase register, move-restart logic, and the half-period select from mode.
- The top-level module holds the 2-stage compare pipeline.

Test Plan:
- Reset then steady hit: mode=1, pos=addr=100, start=13, end=14, row swept 0..15.
  - o_cursor_h=1 exactly for rows 13,14, each 2 cycles after the row is presented.
  - o_cursor_h=0 otherwise and while addr!=100.
- Range edge cases, mode=1 with pos=addr:
  - start=5, end=5: 1 only at row 5.
  - start=9, end=3: never 1.
  - start=0, end=15: 1 on all rows.
- Slow blink, mode=2, BLINK_FRAMES=16:
  - phase=1 for frame pulses 1..15.
  - phase toggles to 0 on the 16th pulse and back to 1 on the 32nd.
  - o_cursor_h is gated accordingly.
- Fast blink plus mode switch:
  - Mode 3: toggle every 8 pulses.
  - Switch from mode 2 with counter=12 to mode 3: the next pulse toggles and clears the counter.
- Move restart: in mode 2 with phase=0 and counter=7, change pos 100->101 on the same cycle as a frame pulse.
  - The next cycle shows phase=1 and counter=0.
  - Cursor is visible at addr 101 two cycles later.
- Reset mid-operation: assert i_rst_h for 1 cycle while o_cursor_h=1 and phase=0.
  - o_cursor_h=0 and phase=1 on the following cycle.
  - Steady mode output resumes after 2 fill cycles.

Source files
------------

// File: rtl/vga_cursor_pkg.sv
// Shared types and constants for the VGA text cursor generator.
// Mode encoding matches the legacy cursor control register.
package vga_cursor_pkg;

    typedef enum logic [1:0] {
        CUR_OFF        = 2'd0,
        CUR_STEADY     = 2'd1,
        CUR_BLINK_SLOW = 2'd2,
        CUR_BLINK_FAST = 2'd3
    } cur_mode_t;

endpackage

// File: rtl/vga_cursor_gen_if.sv
// Cursor generator bus: position/scan inputs and cursor outputs.
// The master drives the scan side, the slave is the generator.
interface vga_cursor_gen_if
    import vga_cursor_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 4
);
    logic [ADDR_W-1:0] i_cur_pos_addr;
    logic [ADDR_W-1:0] i_out_addr_char;
    logic [ROW_W-1:0]  i_char_row;
    logic [ROW_W-1:0]  i_start_row;
    logic [ROW_W-1:0]  i_end_row;
    cur_mode_t         i_mode;
    logic              i_frame_start_h;
    logic              o_cursor_h;
    logic              o_blink_phase_h;

    modport master (
        output i_cur_pos_addr, i_out_addr_char, i_char_row,
        output i_start_row, i_end_row, i_mode, i_frame_start_h,
        input  o_cursor_h, o_blink_phase_h
    );

    modport slave (
        input  i_cur_pos_addr, i_out_addr_char, i_char_row,
        input  i_start_row, i_end_row, i_mode, i_frame_start_h,
        output o_cursor_h, o_blink_phase_h
    );
endinterface

// File: rtl/vga_cursor_blink.sv
// Blink engine: frame-counted phase with restart on cursor moves.
// Half-period follows the mode; an over-range counter wraps on next pulse.
module vga_cursor_blink
    import vga_cursor_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int BLINK_FRAMES = 16,
    parameter int CNT_W        = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_h,
    input  cur_mode_t         i_mode,
    input  logic              i_frame_start_h,
    input  logic [ADDR_W-1:0] i_cur_pos_addr,
    output logic              o_phase_h
);
    localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(BLINK_FRAMES / 2 - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  last_cnt;
    logic              moved;
    logic              blinking;

    assign last_cnt = (i_mode == CUR_BLINK_FAST) ? FAST_M1 : SLOW_M1;
    assign moved    = (i_cur_pos_addr != prev_q);
    assign blinking = (i_mode == CUR_BLINK_SLOW) ||
                      (i_mode == CUR_BLINK_FAST);

    // Next counter/phase: move restart beats idle hold beats frame pulse.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        prev_d  = i_cur_pos_addr;
        if (moved || !blinking) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (i_frame_start_h) begin
            if (cnt_q >= last_cnt) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers with synchronous reset to visible phase.
    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            prev_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            prev_q  <= prev_d;
        end
    end

    assign o_phase_h = phase_q;
endmodule

// File: rtl/vga_cursor_gen.sv
// Cursor generator top: two-stage cell/scanline compare pipeline.
// Stage 2 gates the compare result with the mode-selected enable.
module vga_cursor_gen
    import vga_cursor_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int ROW_W        = 4,
    parameter int BLINK_FRAMES = 16,
    parameter int CNT_W        = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_h,
    vga_cursor_gen_if.slave bus
);
    logic hit1_q, hit1_d;
    logic row1_q, row1_d;
    logic cur_q, cur_d;
    logic phase;
    logic en;

    vga_cursor_blink #(
        .ADDR_W       (ADDR_W),
        .BLINK_FRAMES (BLINK_FRAMES),
        .CNT_W        (CNT_W)
    ) u_blink (
        .i_clk           (i_clk),
        .i_rst_h         (i_rst_h),
        .i_mode          (bus.i_mode),
        .i_frame_start_h (bus.i_frame_start_h),
        .i_cur_pos_addr  (bus.i_cur_pos_addr),
        .o_phase_h       (phase)
    );

    // Stage 1 compare; an inverted range hides the cursor.
    always_comb begin
        hit1_d = (bus.i_cur_pos_addr == bus.i_out_addr_char);
        row1_d = (bus.i_start_row <= bus.i_char_row) &&
                 (bus.i_char_row <= bus.i_end_row);
    end

    // Stage 2 enable from the mode seen at this stage.
    always_comb begin
        en = 1'b0;
        unique case (bus.i_mode)
            CUR_OFF:        en = 1'b0;
            CUR_STEADY:     en = 1'b1;
            CUR_BLINK_SLOW: en = phase;
            CUR_BLINK_FAST: en = phase;
        endcase
        cur_d = hit1_q & row1_q & en;
    end

    // Pipeline registers cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            hit1_q <= 1'b0;
            row1_q <= 1'b0;
            cur_q  <= 1'b0;
        end else begin
            hit1_q <= hit1_d;
            row1_q <= row1_d;
            cur_q  <= cur_d;
        end
    end

    assign bus.o_cursor_h      = cur_q;
    assign bus.o_blink_phase_h = phase;
endmodule

// File: tb/tb_vga_cursor_gen.sv
// Directed bench for vga_cursor_gen: compare pipeline, ranges,
// blink timing, mode switch, move restart and mid-frame reset.
module tb_vga_cursor_gen;
    import vga_cursor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vga_cursor_gen_if #(.ADDR_W(11), .ROW_W(4)) bus ();

    vga_cursor_gen #(
        .ADDR_W       (11),
        .ROW_W        (4),
        .BLINK_FRAMES (16),
        .CNT_W        (5)
    ) dut (
        .i_clk   (clk),
        .i_rst_h (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            bus.i_frame_start_h = 1'b1;
            tick();
            bus.i_frame_start_h = 1'b0;
        end
    endtask

    task automatic present(string tag, logic [3:0] row, logic exp);
        bus.i_char_row = row;
        tick();
        tick();
        chk(tag, bus.o_cursor_h, exp);
    endtask

    logic exp_prev;
    logic exp_cur;

    initial begin
        bus.i_cur_pos_addr  = 11'd0;
        bus.i_out_addr_char = 11'd0;
        bus.i_char_row      = 4'd0;
        bus.i_start_row     = 4'd0;
        bus.i_end_row       = 4'd0;
        bus.i_mode          = CUR_OFF;
        bus.i_frame_start_h = 1'b0;

        // reset state
        tick();
        chk("rst_cursor", bus.o_cursor_h, 1'b0);
        chk("rst_phase", bus.o_blink_phase_h, 1'b1);
        rst = 1'b0;

        // steady sweep, streaming one row per cycle
        bus.i_mode          = CUR_STEADY;
        bus.i_cur_pos_addr  = 11'd100;
        bus.i_out_addr_char = 11'd100;
        bus.i_start_row     = 4'd13;
        bus.i_end_row       = 4'd14;
        bus.i_char_row      = 4'd0;
        tick();
        tick();
        exp_prev = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                bus.i_out_addr_char = 11'd100;
                bus.i_char_row      = 4'(i);
                exp_cur = (i == 13) || (i == 14);
            end else begin
                bus.i_out_addr_char = 11'd99;
                bus.i_char_row      = 4'd13;
                exp_cur = 1'b0;
            end
            tick();
            chk($sformatf("sweep_%0d", i), bus.o_cursor_h, exp_prev);
            exp_prev = exp_cur;
        end
        tick();
        chk("sweep_tail", bus.o_cursor_h, exp_prev);

        // range edge cases
        bus.i_out_addr_char = 11'd100;
        bus.i_start_row     = 4'd5;
        bus.i_end_row       = 4'd5;
        present("single_r4", 4'd4, 1'b0);
        present("single_r5", 4'd5, 1'b1);
        present("single_r6", 4'd6, 1'b0);
        bus.i_start_row = 4'd9;
        bus.i_end_row   = 4'd3;
        present("inv_r3", 4'd3, 1'b0);
        present("inv_r5", 4'd5, 1'b0);
        present("inv_r9", 4'd9, 1'b0);
        bus.i_start_row = 4'd0;
        bus.i_end_row   = 4'd15;
        present("full_r0", 4'd0, 1'b1);
        present("full_r7", 4'd7, 1'b1);
        present("full_r15", 4'd15, 1'b1);

        // mode off gates the cursor
        bus.i_mode = CUR_OFF;
        tick();
        chk("off_gate", bus.o_cursor_h, 1'b0);

        // slow blink: toggle on 16th and 32nd pulse
        bus.i_mode = CUR_BLINK_SLOW;
        tick();
        chk("slow_vis", bus.o_cursor_h, 1'b1);
        pulses(15);
        chk("slow_p15", bus.o_blink_phase_h, 1'b1);
        pulses(1);
        chk("slow_p16", bus.o_blink_phase_h, 1'b0);
        tick();
        chk("slow_gate0", bus.o_cursor_h, 1'b0);
        pulses(15);
        chk("slow_p31", bus.o_blink_phase_h, 1'b0);
        pulses(1);
        chk("slow_p32", bus.o_blink_phase_h, 1'b1);
        tick();
        chk("slow_gate1", bus.o_cursor_h, 1'b1);

        // mode 2 to counter 12, then fast: next pulse toggles
        pulses(12);
        chk("pre_sw", bus.o_blink_phase_h, 1'b1);
        bus.i_mode = CUR_BLINK_FAST;
        pulses(1);
        chk("sw_toggle", bus.o_blink_phase_h, 1'b0);
        pulses(7);
        chk("fast_p7", bus.o_blink_phase_h, 1'b0);
        pulses(1);
        chk("fast_p8", bus.o_blink_phase_h, 1'b1);
        pulses(7);
        chk("fast_p15", bus.o_blink_phase_h, 1'b1);
        pulses(1);
        chk("fast_p16", bus.o_blink_phase_h, 1'b0);

        // move restart: mode 2, phase 0, counter 7
        bus.i_mode = CUR_BLINK_SLOW;
        pulses(7);
        chk("mv_pre", bus.o_blink_phase_h, 1'b0);
        bus.i_cur_pos_addr  = 11'd101;
        bus.i_out_addr_char = 11'd101;
        bus.i_frame_start_h = 1'b1;
        tick();
        bus.i_frame_start_h = 1'b0;
        chk("mv_phase", bus.o_blink_phase_h, 1'b1);
        chk("mv_fill", bus.o_cursor_h, 1'b0);
        tick();
        chk("mv_vis", bus.o_cursor_h, 1'b1);
        pulses(15);
        chk("mv_p15", bus.o_blink_phase_h, 1'b1);
        pulses(1);
        chk("mv_p16", bus.o_blink_phase_h, 1'b0);
        chk("mv_cur_hi", bus.o_cursor_h, 1'b1);

        // reset while cursor on and phase 0
        rst = 1'b1;
        bus.i_mode = CUR_STEADY;
        tick();
        rst = 1'b0;
        chk("mr_cursor", bus.o_cursor_h, 1'b0);
        chk("mr_phase", bus.o_blink_phase_h, 1'b1);
        tick();
        chk("mr_fill", bus.o_cursor_h, 1'b0);
        tick();
        chk("mr_resume", bus.o_cursor_h, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
